spi_word_rx: RTL and testbench

SPI_WORD_RX -- requirements
Module: spi_word_rx

---
 rtl/spi_word_rx.sv | 179 +++++++++++++++++
 tb/tb_spi_word_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_rx.sv
// SPI mode-0 (MSB first) word receiver/transmitter bridging an external SPI master to the core.
// Define SPI_WORD_RX_ABORT_FLAG_EN to add the sticky 'abort' output (CS rose mid-word).
module spi_word_rx #(
   parameter int WORD_BITS   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SPI_clock,
   input  logic                 SPI_not_chip_select,
   input  logic                 SPI_in,
   output logic                 SPI_out,
   output logic [WORD_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic [WORD_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
   output logic                 abort,
`endif
   output logic                 overrun
);

   localparam int CNT_W = $clog2(WORD_BITS);
   localparam int TXC_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
   localparam logic [TXC_W-1:0] TX_DONE  = TXC_W'(WORD_BITS);

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_LOADED = 2'd1,
      TX_SHIFT  = 2'd2
   } tx_state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   sclk_prev_r;
   logic                   cs_prev_r;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise_s;
   logic                   sclk_fall_s;
   logic                   cs_fall_s;
   logic                   cs_rise_s;
   logic                   word_done_s;
   logic                   rx_take_s;
   logic [WORD_BITS-1:0]   rx_word_s;

   logic [CNT_W-1:0]       bit_cnt_r;
   logic [WORD_BITS-1:0]   rx_shift_r;

   tx_state_t              tx_state_r;
   logic [WORD_BITS-1:0]   tx_word_r;
   logic [TXC_W-1:0]       tx_cnt_r;

   // Input synchronizers, reset to the idle bus levels, plus previous-value flops for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_r <= '0;
         cs_sync_r   <= '1;
         mosi_sync_r <= '0;
         sclk_prev_r <= 1'b0;
         cs_prev_r   <= 1'b1;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPI_clock};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPI_not_chip_select};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_in};
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
         cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
      end
   end

   // Edge detection; SCLK edges only count while the synchronized CS is low.
   always_comb begin
      sclk_s      = sclk_sync_r[SYNC_STAGES-1];
      cs_s        = cs_sync_r[SYNC_STAGES-1];
      mosi_s      = mosi_sync_r[SYNC_STAGES-1];
      sclk_rise_s = !cs_s && sclk_s && !sclk_prev_r;
      sclk_fall_s = !cs_s && !sclk_s && sclk_prev_r;
      cs_fall_s   = cs_prev_r && !cs_s;
      cs_rise_s   = !cs_prev_r && cs_s;
      word_done_s = sclk_rise_s && (bit_cnt_r == LAST_BIT);
      rx_word_s   = {rx_shift_r[WORD_BITS-2:0], mosi_s};
      rx_take_s   = !rx_valid || rx_ready;
   end

   // Bit counter and MOSI shift register; any CS edge abandons a partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r  <= '0;
         rx_shift_r <= '0;
      end else if (cs_fall_s || cs_rise_s) begin
         bit_cnt_r  <= '0;
      end else if (sclk_rise_s) begin
         bit_cnt_r  <= word_done_s ? CNT_W'(0) : bit_cnt_r + CNT_W'(1);
         rx_shift_r <= rx_word_s;
      end
   end

   // Received-word holding register; a completed word finding it full is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else if (word_done_s && rx_take_s) begin
         rx_data  <= rx_word_s;
         rx_valid <= 1'b1;
      end else if (word_done_s) begin
         overrun  <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

   // TX FSM. A CS-fall start presents the MSB at once; a wrap start presents it on the next SCLK fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_r <= TX_IDLE;
         tx_ready   <= 1'b1;
         tx_word_r  <= '0;
         tx_cnt_r   <= '0;
         SPI_out    <= 1'b0;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               if (tx_valid && tx_ready) begin
                  tx_word_r  <= tx_data;
                  tx_ready   <= 1'b0;
                  tx_state_r <= TX_LOADED;
               end
            end
            TX_LOADED: begin
               if (cs_fall_s) begin
                  SPI_out    <= tx_word_r[WORD_BITS-1];
                  tx_word_r  <= {tx_word_r[WORD_BITS-2:0], 1'b0};
                  tx_cnt_r   <= TXC_W'(1);
                  tx_state_r <= TX_SHIFT;
               end else if (word_done_s) begin
                  tx_cnt_r   <= '0;
                  tx_state_r <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (cs_rise_s || (sclk_fall_s && tx_cnt_r == TX_DONE)) begin
                  SPI_out    <= 1'b0;
                  tx_ready   <= 1'b1;
                  tx_state_r <= TX_IDLE;
               end else if (sclk_fall_s) begin
                  SPI_out    <= tx_word_r[WORD_BITS-1];
                  tx_word_r  <= {tx_word_r[WORD_BITS-2:0], 1'b0};
                  tx_cnt_r   <= tx_cnt_r + TXC_W'(1);
               end
            end
            default: begin
               SPI_out    <= 1'b0;
               tx_ready   <= 1'b1;
               tx_state_r <= TX_IDLE;
            end
         endcase
      end
   end

`ifdef SPI_WORD_RX_ABORT_FLAG_EN
   // Sticky flag: CS released while a word was partially received.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort <= 1'b0;
      end else if (cs_rise_s && (bit_cnt_r != '0)) begin
         abort <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Randomized scoreboard bench for spi_word_rx: SPI master model drives frames, monitor checks deliveries.
`timescale 1ns/1ps
module tb_spi_word_rx;
   localparam int W    = 32;
   localparam int S    = 2;
   localparam int HALF = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sclk = 1'b0;
   logic         csn = 1'b1;
   logic         mosi = 1'b0;
   logic         spi_out;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready;
   logic         overrun;
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
   logic         abort;
`endif

   int           tests = 0;
   int           fails = 0;
   int           tx_caps = 0;
   logic [W-1:0] rx_exp_q[$];
   logic [W-1:0] miso_word = '0;
   logic         rand_en = 1'b0;
   logic         ready_cmd = 1'b1;
   logic         rnd_ready = 1'b1;

   assign rx_ready = rand_en ? rnd_ready : ready_cmd;

   always #5 clk = ~clk;

   spi_word_rx #(.WORD_BITS(W), .SYNC_STAGES(S)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .SPI_clock           (sclk),
      .SPI_not_chip_select (csn),
      .SPI_in              (mosi),
      .SPI_out             (spi_out),
      .rx_data             (rx_data),
      .rx_valid            (rx_valid),
      .rx_ready            (rx_ready),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_ready            (tx_ready),
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
      .abort               (abort),
`endif
      .overrun             (overrun)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rx transfer must match the oldest expected word.
   initial begin
      logic [W-1:0] exp_w;
      forever begin
         @(negedge clk);
         if (rst_n && tx_valid && tx_ready) tx_caps++;
         if (rst_n && rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rx_unexpected: got word %h, expected no transfer", rx_data);
            end else begin
               exp_w = rx_exp_q.pop_front();
               check("rx_data", rx_data, exp_w);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Shift nbits of word MSB first; sync_last pulses rx_ready exactly when the last bit completes.
   task automatic spi_bits(input logic [W-1:0] word, input int nbits, input bit sync_last);
      for (int i = 0; i < nbits; i++) begin
         mosi = word[W-1-i];
         cyc(HALF);
         miso_word = {miso_word[W-2:0], spi_out};
         sclk = 1'b1;
         if (sync_last && i == nbits - 1) begin
            cyc(S);
            ready_cmd = 1'b1;
            cyc(1);
            ready_cmd = 1'b0;
            cyc(HALF - S - 1);
         end else begin
            cyc(HALF);
         end
         sclk = 1'b0;
      end
      mosi = 1'b0;
   endtask

   task automatic frame(input logic [W-1:0] word, input int nbits, input bit sync_last);
      miso_word = '0;
      csn = 1'b0;
      cyc(HALF);
      spi_bits(word, nbits, sync_last);
      cyc(HALF);
      csn = 1'b1;
      cyc(HALF);
   endtask

   task automatic offer_tx(input logic [W-1:0] word);
      check("tx_ready_idle", W'(tx_ready), W'(1));
      tx_data  = word;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (rx_exp_q.size() != 0 && n < 300) begin
         cyc(1);
         n++;
      end
      check(name, W'(rx_exp_q.size()), W'(0));
      rx_exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      csn = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      tx_valid = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] txw;
      logic         has_tx;
      int           caps0;

      // Reset state
      cyc(2);
      check("rst_rx_valid", W'(rx_valid), W'(0));
      check("rst_rx_data", rx_data, W'(0));
      check("rst_overrun", W'(overrun), W'(0));
      check("rst_spi_out", W'(spi_out), W'(0));
      check("rst_tx_ready", W'(tx_ready), W'(1));
      rst_n = 1'b1;
      cyc(3);

      // Basic receive plus one transmitted result
      ready_cmd = 1'b1;
      caps0 = tx_caps;
      offer_tx(32'hC0490FDB);
      rx_exp_q.push_back(32'h3F800000);
      frame(32'h3F800000, W, 1'b0);
      check("tx_miso_word", miso_word, 32'hC0490FDB);
      check("tx_capture_count", W'(tx_caps - caps0), W'(1));
      check("spi_out_after_cs", W'(spi_out), W'(0));
      drain("drain_basic");
      check("rx_valid_single", W'(rx_valid), W'(0));
      check("basic_overrun", W'(overrun), W'(0));
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
      check("abort_full_frame", W'(abort), W'(0));
`endif

      // Randomized frames with random backpressure and optional results
      rand_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         w      = $urandom;
         txw    = $urandom;
         has_tx = 1'($urandom_range(0, 1));
         if (has_tx) offer_tx(txw);
         rx_exp_q.push_back(w);
         frame(w, W, 1'b0);
         check("rand_miso_word", miso_word, has_tx ? txw : W'(0));
      end
      rand_en = 1'b0;
      ready_cmd = 1'b1;
      drain("drain_random");
      check("random_overrun", W'(overrun), W'(0));

      // Overrun: second word dropped while the first is held
      do_reset();
      ready_cmd = 1'b0;
      rx_exp_q.push_back(32'h11111111);
      frame(32'h11111111, W, 1'b0);
      frame(32'h22222222, W, 1'b0);
      cyc(2);
      check("ovr_rx_data_held", rx_data, 32'h11111111);
      check("ovr_rx_valid", W'(rx_valid), W'(1));
      check("ovr_flag", W'(overrun), W'(1));
      ready_cmd = 1'b1;
      drain("drain_overrun");
      cyc(2);
      check("ovr_rx_valid_after", W'(rx_valid), W'(0));
      check("ovr_flag_sticky", W'(overrun), W'(1));

      // CS released after 13 bits, then a full word
      do_reset();
      ready_cmd = 1'b1;
      frame(32'hA5A5A5A5, 13, 1'b0);
      rx_exp_q.push_back(32'h40000000);
      frame(32'h40000000, W, 1'b0);
      drain("drain_abort");
      check("abort_case_overrun", W'(overrun), W'(0));
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
      check("abort_flag", W'(abort), W'(1));
`endif

      // New word completes in the same cycle the held word transfers
      do_reset();
      ready_cmd = 1'b0;
      w   = $urandom;
      txw = $urandom;
      rx_exp_q.push_back(w);
      rx_exp_q.push_back(txw);
      frame(w, W, 1'b0);
      frame(txw, W, 1'b1);
      check("b2b_rx_valid", W'(rx_valid), W'(1));
      check("b2b_rx_data", rx_data, txw);
      check("b2b_overrun", W'(overrun), W'(0));
      ready_cmd = 1'b1;
      drain("drain_b2b");

      // Asynchronous reset mid-word
      do_reset();
      ready_cmd = 1'b0;
      frame(32'h12345678, W, 1'b0);
      frame(32'h9ABCDEF0, W, 1'b0);
      offer_tx(32'hFFFFFFFF);
      csn = 1'b0;
      cyc(HALF);
      spi_bits(32'h0F0F0F0F, 20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rx_valid", W'(rx_valid), W'(0));
      check("arst_rx_data", rx_data, W'(0));
      check("arst_overrun", W'(overrun), W'(0));
      check("arst_spi_out", W'(spi_out), W'(0));
      check("arst_tx_ready", W'(tx_ready), W'(1));
`ifdef SPI_WORD_RX_ABORT_FLAG_EN
      check("arst_abort", W'(abort), W'(0));
`endif
      csn = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      ready_cmd = 1'b1;
      w = $urandom;
      rx_exp_q.push_back(w);
      frame(w, W, 1'b0);
      drain("drain_after_reset");
      check("post_reset_overrun", W'(overrun), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
